// File: rtl/booth_mul_sched_if.sv
// booth_mul_sched_if
//   Client-side bundle of the shared Booth multiplier scheduler: per-requester
//   request levels and operands, the one-hot grant pulse, and the tagged
//   valid/ready response channel.
//
//   req      requester -> sched  N_REQ    request level, held until granted
//   req_mc   requester -> sched  8*N_REQ  signed multiplicands, slice i = requester i
//   req_mp   requester -> sched  8*N_REQ  signed multipliers, slice i = requester i
//   gnt      sched -> requester  N_REQ    one-hot pulse, operands latched
//   rsp_*    sched -> consumer            valid/id/prd/err response, rsp_ready back
//
//   slave  : the scheduler side
//   master : the client/consumer side
interface booth_mul_sched_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_mc;
  logic [8*N_REQ-1:0] req_mp;
  logic [N_REQ-1:0]   gnt;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [15:0]        rsp_prd;
  logic               rsp_err;

  modport slave (
    input  req, req_mc, req_mp, rsp_ready,
    output gnt, rsp_valid, rsp_id, rsp_prd, rsp_err
  );

  modport master (
    output req, req_mc, req_mp, rsp_ready,
    input  gnt, rsp_valid, rsp_id, rsp_prd, rsp_err
  );
endinterface

// File: rtl/booth_mul_sched.sv
// booth_mul_sched
//   Round-robin scheduler sharing one sequential 8x8 signed Booth multiplier
//   (start/busy/prd, 8 iterations) between N_REQ requesters. One job is in
//   flight at a time: IDLE arbitrates and latches operands, ISSUE pulses the
//   multiplier start and the grant, WAIT captures the product in the first
//   busy-low cycle (or aborts after TIMEOUT cycles), RESP holds the tagged
//   result until the consumer takes it. All outputs are registered.
//
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   cli              client bundle (slave modport): req/req_mc/req_mp/gnt and
//                    the rsp_valid/rsp_ready/rsp_id/rsp_prd/rsp_err channel
//   mul_start        start pulse to the multiplier
//   mul_mc, mul_mp   operands to the multiplier, held for the whole job
//   mul_busy         multiplier busy flag
//   mul_prd          multiplier product, taken verbatim
//   idle             high while the state machine is in IDLE
module booth_mul_sched #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  booth_mul_sched_if.slave       cli,
  output logic                   mul_start,
  output logic [7:0]             mul_mc,
  output logic [7:0]             mul_mp,
  input  logic                   mul_busy,
  input  logic [15:0]            mul_prd,
  output logic                   idle
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam int N_EXT = 2 ** ID_W;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              start_q, start_d;
  logic [7:0]        mc_q, mc_d;
  logic [7:0]        mp_q, mp_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [15:0]       rsp_prd_q, rsp_prd_d;
  logic              rsp_err_q, rsp_err_d;
  logic              idle_q, idle_d;

  // Requests and operands are padded to the full id range so every select
  // below uses an exact-width index; padded requesters never request.
  logic [N_EXT-1:0]   req_ext;
  logic [8*N_EXT-1:0] mc_ext;
  logic [8*N_EXT-1:0] mp_ext;

  assign req_ext = N_EXT'(cli.req);
  assign mc_ext  = (8*N_EXT)'(cli.req_mc);
  assign mp_ext  = (8*N_EXT)'(cli.req_mp);

  logic              found;
  logic [ID_W-1:0]   sel;
  logic [ID_W-1:0]   cand;
  logic [ID_W:0]     cand_sum;
  logic [7:0]        sel_mc;
  logic [7:0]        sel_mp;

  // Round-robin pick: first set request at or above ptr, wrapping modulo
  // N_REQ (not modulo 2**ID_W, so a non-power-of-two N_REQ wraps correctly).
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    cand     = '0;
    cand_sum = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_sum = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (cand_sum >= (ID_W+1)'(N_REQ)) begin
        cand_sum = cand_sum - (ID_W+1)'(N_REQ);
      end
      cand = cand_sum[ID_W-1:0];
      if (!found && req_ext[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    sel_mc = '0;
    sel_mp = '0;
    for (int k = 0; k < N_EXT; k++) begin
      if (sel == ID_W'(k)) begin
        sel_mc = mc_ext[8*k +: 8];
        sel_mp = mp_ext[8*k +: 8];
      end
    end
  end

  // Next-state and next-output logic. gnt/mul_start are computed on the
  // IDLE->ISSUE transition so the registered pulses land in the ISSUE cycle.
  // mul_busy is only looked at in WAIT: during ISSUE it may still describe
  // the previous job.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cur_id_d    = cur_id_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    start_d     = 1'b0;
    mc_d        = mc_q;
    mp_d        = mp_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_prd_d   = rsp_prd_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          mc_d     = sel_mc;
          mp_d     = sel_mp;
          cur_id_d = sel;
          ptr_d    = (sel == ID_W'(N_REQ-1)) ? '0 : sel + 1'b1;
          gnt_d    = N_REQ'(1) << sel;
          start_d  = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // The multiplier keeps shifting after it finishes, so the product is
        // only valid in the very first busy-low cycle.
        if (!mul_busy) begin
          rsp_prd_d   = mul_prd;
          rsp_id_d    = cur_id_q;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
          rsp_prd_d   = '0;
          rsp_id_d    = cur_id_q;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (cli.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    idle_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cur_id_q    <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      start_q     <= 1'b0;
      mc_q        <= '0;
      mp_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_prd_q   <= '0;
      rsp_err_q   <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cur_id_q    <= cur_id_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      start_q     <= start_d;
      mc_q        <= mc_d;
      mp_q        <= mp_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_prd_q   <= rsp_prd_d;
      rsp_err_q   <= rsp_err_d;
      idle_q      <= idle_d;
    end
  end

  assign cli.gnt       = gnt_q;
  assign cli.rsp_valid = rsp_valid_q;
  assign cli.rsp_id    = rsp_id_q;
  assign cli.rsp_prd   = rsp_prd_q;
  assign cli.rsp_err   = rsp_err_q;
  assign mul_start     = start_q;
  assign mul_mc        = mc_q;
  assign mul_mp        = mp_q;
  assign idle          = idle_q;

endmodule

// File: doc/booth_mul_sched.md
Name: booth_mul_sched

Overview:
- Round-robin scheduler that shares one sequential 8x8 signed Booth multiplier (start/busy/prd interface, 8 iterations) between N_REQ requesters.
- Accepts operands from one requester at a time and pulses the multiplier start.
- Captures the 16-bit product in the first cycle busy is low, then returns it tagged with the requester id over a valid/ready response channel.
- Sits between client blocks and the single multiplier instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester id; must satisfy 2**ID_W >= N_REQ.
- TIMEOUT, 12, maximum WAIT cycles before the operation is aborted (>= 10).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester request level; held until granted.
- req_mc  in  8*N_REQ  signed multiplicands; slice i belongs to requester i.
- req_mp  in  8*N_REQ  signed multipliers; slice i belongs to requester i.
- gnt  out  N_REQ  one-hot, one-cycle pulse: operands of that requester were latched.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_prd  out  16  signed product.
- rsp_err  out  1  qualifies rsp_valid; set when the operation timed out.
- mul_start  out  1  start pulse to the multiplier.
- mul_mc  out  8  multiplicand to the multiplier.
- mul_mp  out  8  multiplier operand to the multiplier.
- mul_busy  in  1  multiplier busy flag.
- mul_prd  in  16  multiplier product.
- idle  out  1  high when the state machine is in IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; gnt=0, mul_start=0, mul_mc=0, mul_mp=0, rsp_valid=0, rsp_id=0, rsp_prd=0, rsp_err=0, idle=1.
  - Round-robin pointer=0, so requester 0 has highest priority.
  - Reset mid-operation abandons the job silently, with no response. The multiplier has no reset; the next start fully reinitialises it.
- All outputs are registered.
- IDLE:
  - If any req bit is set, select the first set bit searching from ptr upward, wrapping modulo N_REQ.
  - Latch that requester's mc/mp into mul_mc/mul_mp and its index into cur_id.
  - Set ptr = (cur_id+1) mod N_REQ. Go to ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mul_start=1 and gnt[cur_id]=1.
  - Clear the wait counter. Go to WAIT.
  - The requester may drop req or change its operands from the next cycle.
- WAIT:
  - mul_start=0; mul_mc/mul_mp are held.
  - mul_busy is not examined in the ISSUE cycle, because it may still reflect the previous job.
  - In each WAIT cycle:
    - If mul_busy=0: rsp_prd<=mul_prd, rsp_id<=cur_id, rsp_err<=0, rsp_valid<=1; go to RESP.
    - Else if wait counter = TIMEOUT-1: rsp_prd<=0, rsp_err<=1, rsp_valid<=1; go to RESP.
    - Else increment the wait counter.
  - The product must be captured in the first busy-low cycle, because the multiplier keeps shifting afterwards.
- RESP:
  - rsp_* are held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid & rsp_ready: rsp_valid<=0, rsp_err<=0; go to IDLE.
  - There is no new arbitration during RESP (one bubble cycle).
- Latency: request first seen in IDLE at cycle t → gnt and mul_start at t+1 → mul_busy low at t+10 → rsp_valid high at t+11 (with an 8-iteration multiplier).
- Throughput: one job every 12 cycles when rsp_ready is held at 1.
- Simultaneous events:
  - A req arriving during ISSUE/WAIT/RESP waits for the next IDLE.
  - A requester whose req drops before its grant is simply skipped.
- Arithmetic: two's complement signed; the product is taken verbatim from mul_prd, with no width change.

Test Plan:
- Single requester: req[0]=1, mc=7, mp=-3 at t → gnt=4'b0001 at t+1, rsp_valid at t+11, rsp_prd=16'hFFEB, rsp_id=0, rsp_err=0.
- All four requesters request together (mc=i+1, mp=10) with rsp_ready=1 → grants in order 0,1,2,3; products 10,20,30,40; gnt pulses 12 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_prd/rsp_id stable, no mul_start; result 2 accepted in the first cycle rsp_ready=1, then IDLE.
- Extremes: mc=-128, mp=-128 → 16'h4000; mc=-128, mp=127 → 16'hC080; mc=0, mp=-1 → 16'h0000.
- Stuck multiplier: mul_busy forced 1 → after TIMEOUT WAIT cycles rsp_valid=1, rsp_err=1, rsp_prd=0; the next job completes normally.
- rst_n pulsed low mid-WAIT → outputs go to reset values immediately, no response for the aborted job; a new req[2] job afterwards returns the correct product with rsp_id=2.
